// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 3-stage pipeline stall/flush sequencer:
//   - state_t      : sequencer state encoding (2 bits)
//   - R15          : register number of the PC, never a load-use source
//   - USE_RN/RS/RM : bit positions in the decode-stage operand-use mask
//   - operand_hit  : helper comparing one decode operand against the load rd
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] R15 = 4'd15;

    localparam int USE_RN = 0;
    localparam int USE_RS = 1;
    localparam int USE_RM = 2;

    // True when the operand is actually read and names the load destination.
    function automatic logic operand_hit(
        input logic       use_bit,
        input logic [3:0] src,
        input logic [3:0] rd
    );
        return use_bit & (src == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the performance counters.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count this cycle
//   count : current value, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
// Central stall/flush sequencer for the fetch/decode/execute pipeline.
// Resolves load-use hazards (one bubble), data-memory wait states (full hold)
// and taken branches (PC redirect plus FLUSH_CYCLES cycles of flush).
//
// Parameters:
//   FLUSH_CYCLES : flush-high cycles per taken branch incl. detection (2..15)
//   CNT_W        : performance counter width
// Inputs:
//   clk, rst_n                         : clock, async active-low reset
//   dec_valid, dec_rn/rs/rm, dec_uses  : decode-stage instruction and operands
//   ex_valid, ex_is_load, ex_rd        : execute-stage instruction
//   branch_taken                       : execute-stage branch resolved taken
//   mem_req, mem_ready                 : data-memory handshake
// Outputs:
//   sel_stall_fd, sel_stall_ex         : hold F/D and EX registers
//   sel_bubble_ex                      : load NOP into EX
//   flush, pc_redirect                 : squash F/D, PC takes branch target
//   busy                               : sequencer not in RUN
//   stall_cycles, flush_events         : saturating performance counters
// Control outputs are combinational from state and inputs so a hazard is
// answered in the cycle it is detected.
// -----------------------------------------------------------------------------
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [3:0]       dec_rn,
    input  logic [3:0]       dec_rs,
    input  logic [3:0]       dec_rm,
    input  logic [2:0]       dec_uses,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             sel_stall_fd,
    output logic             sel_stall_ex,
    output logic             sel_bubble_ex,
    output logic             flush,
    output logic             pc_redirect,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Detection cycle counts as the first flush cycle, so FLUSH state lasts
    // FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_lu_hz;
    logic w_mem_stall;
    logic w_sel_stall_fd;
    logic w_sel_stall_ex;
    logic w_sel_bubble_ex;
    logic w_flush;
    logic w_pc_redirect;
    logic w_busy;

    // A load writing R15 is a branch, handled by the branch path, not a hazard.
    assign w_lu_hz = ex_valid & ex_is_load & dec_valid & (ex_rd != R15) &
                     (operand_hit(dec_uses[USE_RN], dec_rn, ex_rd) |
                      operand_hit(dec_uses[USE_RS], dec_rs, ex_rd) |
                      operand_hit(dec_uses[USE_RM], dec_rm, ex_rd));

    assign w_mem_stall = mem_req & ~mem_ready;

    // Sequencer state and flush-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken) begin
                        r_state <= FLUSH;
                        r_cnt   <= FLUSH_LOAD;
                    end else if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                        r_cnt   <= r_cnt;
                    end else begin
                        r_state <= RUN;
                        r_cnt   <= r_cnt;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= MEM_WAIT;
                    end
                    r_cnt <= r_cnt;
                end
                FLUSH: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= FLUSH;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Control selects from state and live inputs; all forced low during reset
    // so the stage units see a quiet pipeline the moment rst_n drops.
    always_comb begin
        w_sel_stall_fd  = 1'b0;
        w_sel_stall_ex  = 1'b0;
        w_sel_bubble_ex = 1'b0;
        w_flush         = 1'b0;
        w_pc_redirect   = 1'b0;
        w_busy          = 1'b0;
        if (rst_n) begin
            case (r_state)
                RUN: begin
                    if (branch_taken) begin
                        w_flush         = 1'b1;
                        w_pc_redirect   = 1'b1;
                        w_sel_bubble_ex = 1'b1;
                    end else if (w_mem_stall) begin
                        w_sel_stall_fd = 1'b1;
                        w_sel_stall_ex = 1'b1;
                    end else if (w_lu_hz) begin
                        // Bubble lets the load reach writeback; next cycle EX
                        // holds the NOP so the hazard cannot repeat.
                        w_sel_stall_fd  = 1'b1;
                        w_sel_bubble_ex = 1'b1;
                    end else begin
                        w_sel_stall_fd = 1'b0;
                    end
                end
                MEM_WAIT: begin
                    w_busy         = 1'b1;
                    w_sel_stall_fd = ~mem_ready;
                    w_sel_stall_ex = ~mem_ready;
                end
                FLUSH: begin
                    w_busy          = 1'b1;
                    w_flush         = 1'b1;
                    w_sel_bubble_ex = 1'b1;
                end
                default: begin
                    w_busy = 1'b1;
                end
            endcase
        end else begin
            w_busy = 1'b0;
        end
    end

    assign sel_stall_fd  = w_sel_stall_fd;
    assign sel_stall_ex  = w_sel_stall_ex;
    assign sel_bubble_ex = w_sel_bubble_ex;
    assign flush         = w_flush;
    assign pc_redirect   = w_pc_redirect;
    assign busy          = w_busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sel_stall_fd),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pc_redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid;
    logic [3:0] dec_rn, dec_rs, dec_rm;
    logic [2:0] dec_uses;
    logic       ex_valid, ex_is_load;
    logic [3:0] ex_rd;
    logic       bt_a, bt_b;
    logic       mem_req, mem_ready;

    logic        sfd_a, sex_a, bub_a, fl_a, pc_a, busy_a;
    logic [15:0] sc_a, fe_a;
    logic        sfd_b, sex_b, bub_b, fl_b, pc_b, busy_b;
    logic [3:0]  sc_b, fe_b;

    logic [5:0] ctrl_a, ctrl_b;
    assign ctrl_a = {sfd_a, sex_a, bub_a, fl_a, pc_a, busy_a};
    assign ctrl_b = {sfd_b, sex_b, bub_b, fl_b, pc_b, busy_b};

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_stall_controller dut_a (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rn(dec_rn),
        .dec_rs(dec_rs), .dec_rm(dec_rm), .dec_uses(dec_uses),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .branch_taken(bt_a), .mem_req(mem_req), .mem_ready(mem_ready),
        .sel_stall_fd(sfd_a), .sel_stall_ex(sex_a), .sel_bubble_ex(bub_a),
        .flush(fl_a), .pc_redirect(pc_a), .busy(busy_a),
        .stall_cycles(sc_a), .flush_events(fe_a)
    );

    hazard_stall_controller #(.FLUSH_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rn(dec_rn),
        .dec_rs(dec_rs), .dec_rm(dec_rm), .dec_uses(dec_uses),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .branch_taken(bt_b), .mem_req(mem_req), .mem_ready(mem_ready),
        .sel_stall_fd(sfd_b), .sel_stall_ex(sex_b), .sel_bubble_ex(bub_b),
        .flush(fl_b), .pc_redirect(pc_b), .busy(busy_b),
        .stall_cycles(sc_b), .flush_events(fe_b)
    );

    // ctrl vector order: {stall_fd, stall_ex, bubble_ex, flush, pc_redirect, busy}
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_rn = 4'd0; dec_rs = 4'd0; dec_rm = 4'd0;
        dec_uses = 3'b000; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 4'd0;
        bt_a = 1'b0; bt_b = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu(input logic [3:0] rd, input logic [3:0] rn,
                          input logic [3:0] rs, input logic [3:0] rm,
                          input logic [2:0] uses);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; dec_valid = 1'b1;
        dec_rn = rn; dec_rs = rs; dec_rm = rm; dec_uses = uses;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("reset_ctrl_a", 32'(ctrl_a), 32'h0);
        chk("reset_ctrl_b", 32'(ctrl_b), 32'h0);
        chk("reset_stall_cnt", 32'(sc_a), 32'h0);
        chk("reset_flush_cnt", 32'(fe_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Load-use on Rn
        set_lu(4'd3, 4'd3, 4'd0, 4'd0, 3'b001);
        @(negedge clk);
        chk("lu_rn_ctrl", 32'(ctrl_a), 32'h28);
        next_cycle();
        idle();
        @(negedge clk);
        chk("lu_rn_release", 32'(ctrl_a), 32'h0);
        chk("lu_rn_stall_cnt", 32'(sc_a), 32'd1);
        next_cycle();

        // R15 is never a hazard
        set_lu(4'd15, 4'd15, 4'd0, 4'd0, 3'b001);
        @(negedge clk);
        chk("lu_r15_ctrl", 32'(ctrl_a), 32'h0);
        next_cycle();

        // Load-use on Rm
        set_lu(4'd7, 4'd0, 4'd0, 4'd7, 3'b100);
        @(negedge clk);
        chk("lu_rm_ctrl", 32'(ctrl_a), 32'h28);
        chk("lu_rm_cnt_before", 32'(sc_a), 32'd1);
        next_cycle();

        // Matching Rs not in use mask
        set_lu(4'd7, 4'd0, 4'd7, 4'd0, 3'b001);
        @(negedge clk);
        chk("lu_mask_ctrl", 32'(ctrl_a), 32'h0);
        chk("lu_mask_cnt", 32'(sc_a), 32'd2);
        next_cycle();

        // Memory wait: 3 stalled cycles, branch mid-wait ignored
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("mw_detect", 32'(ctrl_a), 32'h30);
        next_cycle();
        @(negedge clk);
        chk("mw_hold", 32'(ctrl_a), 32'h31);
        next_cycle();
        bt_a = 1'b1; bt_b = 1'b1;
        @(negedge clk);
        chk("mw_branch_ignored_a", 32'(ctrl_a), 32'h31);
        chk("mw_branch_ignored_b", 32'(ctrl_b), 32'h31);
        next_cycle();
        bt_a = 1'b0; bt_b = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_ready", 32'(ctrl_a), 32'h01);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mw_back_run", 32'(ctrl_a), 32'h0);
        chk("mw_stall_cnt", 32'(sc_a), 32'd5);
        chk("mw_no_flush", 32'(fe_a), 32'd0);
        next_cycle();

        // Branch: 2-cycle flush on A, 4-cycle flush on B with repeat branches ignored
        bt_a = 1'b1; bt_b = 1'b1;
        @(negedge clk);
        chk("br_detect_a", 32'(ctrl_a), 32'h0E);
        chk("br_detect_b", 32'(ctrl_b), 32'h0E);
        next_cycle();
        bt_a = 1'b0; bt_b = 1'b1;
        @(negedge clk);
        chk("br_flush2_a", 32'(ctrl_a), 32'h0D);
        chk("br_flush2_b", 32'(ctrl_b), 32'h0D);
        chk("br_events_a", 32'(fe_a), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("br_done_a", 32'(ctrl_a), 32'h0);
        chk("br_flush3_b", 32'(ctrl_b), 32'h0D);
        next_cycle();
        bt_b = 1'b0;
        @(negedge clk);
        chk("br_flush4_b", 32'(ctrl_b), 32'h0D);
        next_cycle();
        @(negedge clk);
        chk("br_done_b", 32'(ctrl_b), 32'h0);
        chk("br_events_b", 32'(fe_b), 32'd1);
        next_cycle();

        // Simultaneous branch, memory stall and load-use: branch wins
        set_lu(4'd3, 4'd3, 4'd0, 4'd0, 3'b001);
        bt_a = 1'b1; bt_b = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("sim_ctrl", 32'(ctrl_a), 32'h0E);
        next_cycle();
        bt_a = 1'b0; bt_b = 1'b0;
        @(negedge clk);
        chk("sim_flush_state", 32'(ctrl_a), 32'h0D);
        chk("sim_no_stall_cnt", 32'(sc_a), 32'd5);
        chk("sim_events", 32'(fe_a), 32'd2);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("sim_drain_a", 32'(ctrl_a), 32'h0);
        chk("sim_drain_b", 32'(ctrl_b), 32'h0);
        next_cycle();

        // Reset during second cycle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mw_detect", 32'(ctrl_a), 32'h30);
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl_a", 32'(ctrl_a), 32'h0);
        chk("rst_async_ctrl_b", 32'(ctrl_b), 32'h0);
        chk("rst_async_sc_a", 32'(sc_a), 32'h0);
        chk("rst_async_fe_a", 32'(fe_a), 32'h0);
        chk("rst_async_sc_b", 32'(sc_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        next_cycle();
        @(negedge clk);
        chk("rst_release_run", 32'(ctrl_a), 32'h0);
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_ready_no_stall", 32'(ctrl_a), 32'h0);
        next_cycle();

        // Saturation: 20 load-use stalls on the 4-bit counter
        set_lu(4'd5, 4'd0, 4'd5, 4'd0, 3'b010);
        mem_req = 1'b0; mem_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("sat_cnt_a", 32'(sc_a), 32'd20);
        chk("sat_cnt_b", 32'(sc_b), 32'd15);
        next_cycle();
        set_lu(4'd5, 4'd0, 4'd5, 4'd0, 3'b010);
        @(negedge clk);
        chk("sat_extra_ctrl_b", 32'(ctrl_b), 32'h28);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sat_hold_b", 32'(sc_b), 32'd15);
        chk("sat_grow_a", 32'(sc_a), 32'd21);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
